axi_pack_strided_reader: RTL and testbench
==========================================

Name: axi_pack_strided_reader

Overview:
- Initiator on the packed (SSR) AXI read interface: turns a strided-read job descriptor into packed AR bursts.
- Element stride is carried in AR user; element size in AR size.
- Returned packed R beats are unpacked into a one-element-per-cycle output stream.
- Sits between a streamer/accelerator and the packed-to-standard converter; read-only.

Parameters:
- AddrWidth, 48, address width.
- DataWidth, 64, packed R data width; power of two, >= 64.
- AxiIdWidth, 4, AR/R id width; all bursts use id 0.
- MaxBurstBeats, 16, max beats per AR burst (1..256).
- NumOutstanding, 4, max AR bursts in flight; depth of the burst-info FIFO.
- axi_ssr_req_t / axi_ssr_rsp_t, logic, packed AXI request/response struct types.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- desc_valid_i  in  1  descriptor valid
- desc_ready_o  out  1  descriptor accepted when high with valid
- desc_addr_i  in  AddrWidth  byte address of element 0
- desc_stride_i  in  axi_pack_pkg::stride_t  byte distance between elements (0 legal)
- desc_size_i  in  3  log2 element bytes, 0..3
- desc_num_i  in  16  element count, >= 1
- desc_signed_i  in  1  sign-extend elements (see Optional Feature)
- elem_o  out  64  element, right-aligned, extended to 64 bits
- elem_last_o  out  1  final element of the job
- elem_valid_o  out  1  element valid
- elem_ready_i  in  1  element consumed
- err_o  out  1  sticky: an R beat had resp != OKAY; cleared on next descriptor accept
- busy_o  out  1  job in progress
- axi_ssr_req_o  out  axi_ssr_req_t  packed AXI request; aw/w/b tied inactive, b_ready=1
- axi_ssr_rsp_i  in  axi_ssr_rsp_t  packed AXI response

Behaviour:
- Reset values: desc_ready_o=1, elem_valid_o=0, elem_o=0, elem_last_o=0, err_o=0, busy_o=0, ar_valid=0, r_ready=0.
- EPB (elements per beat) = (DataWidth/8) >> size.
- AR FSM IDLE -> ISSUE -> DRAIN -> IDLE:
  - IDLE: desc_ready_o=1. Accept on desc_valid_i & desc_ready_o; latch descriptor; remaining=num; go to ISSUE; busy_o=1 from the next cycle.
  - ISSUE: burst_elems = min(remaining, MaxBurstBeats*EPB). AR fields: addr=cur_addr, size=desc size, len=ceil(burst_elems/EPB)-1, burst=INCR, id=0, user.stride=stride.
  - ar_valid is held stable until ar_ready; it is asserted only when the burst FIFO is not full.
  - On handshake: push burst_elems into the burst FIFO; cur_addr += burst_elems*stride (mod 2^AddrWidth); remaining -= burst_elems. When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until the final element is handed off, then IDLE. desc_ready_o=0 outside IDLE.
- R unpack:
  - Element k of a beat is bytes [k<<size +: 1<<size] of r.data.
  - The head FIFO entry gives the burst's remaining element count. The last beat of a burst may be partial; unused lanes are dropped.
  - r_ready is asserted only in the cycle the last used element of the current beat handshakes on the output. Zero-bubble: one element per cycle under continuous ready.
  - Pop the FIFO when the burst count reaches 0. Beat r.last must coincide; a mismatch sets err_o.
- elem_last_o=1 exactly on the job's num-th element.
- Output hold: elem_o and elem_last_o stay stable while elem_valid_o & ~elem_ready_i.
- Simultaneous FIFO push (AR handshake) and pop (burst end) are both taken; occupancy is unchanged.
- Full FIFO: ar_valid stays low; no AR is dropped.
- Reset mid-job: all state cleared immediately. Outstanding R beats arriving after reset are the system's responsibility; resets happen only with the bus idle.

Optional Feature:
- Macro AXI_PACK_READER_SIGN_EXT_EN.
- Defined: when desc_signed_i was latched high, elem_o is sign-extended from bit (8<<size)-1.
- Undefined: desc_signed_i is ignored and elements are always zero-extended.

Test Plan:
- DataWidth=64, addr=0x1000, stride=16, size=2, num=5 -> one AR (addr 0x1000, len 2, size 2, user.stride 16). 3 R beats yield 5 elements; beat 2 upper lane dropped; elem_last_o on element 5; r_ready pulses exactly 3 times.
- size=0, num=40, MaxBurstBeats=4, stride=3, addr=0x200 -> AR0 (0x200, len 3, 32 elems), AR1 (0x260, len 0, 8 elems); 40 elements in order, one per cycle under continuous ready.
- NumOutstanding=2, arready=1, R stalled -> exactly 2 ARs issued, then ar_valid low until the first burst completes.
- Random elem_ready_i throttling (50%) over num=100 -> no element lost or duplicated; outputs stable while stalled.
- One R beat with resp=SLVERR -> err_o set and held; data still delivered; cleared on the next descriptor accept.
- With AXI_PACK_READER_SIGN_EXT_EN, size=0, signed=1, byte 0x80 -> elem_o=0xFFFF_FFFF_FFFF_FF80. Without the macro -> 0x80.

Source files
------------

// File: rtl/axi_pack_strided_reader.sv
// Strided reader on the packed (SSR) AXI read channel: one job descriptor -> packed AR bursts -> unpacked element stream.
// Latency: AR goes out the cycle after accept; elements are passed straight through from R (no added latency).
// Backpressure: R beats are held until their last used element is taken; AR is withheld while the burst FIFO is full.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   desc_*                         job descriptor (valid/ready): addr, stride, size, num, signed
//   elem_o/_last_o/_valid_o/_ready_i   one element per cycle, right-aligned and extended to 64 bits
//   err_o                          sticky response error, cleared when the next descriptor is accepted
//   busy_o                         a job is in progress
//   axi_ssr_req_o / axi_ssr_rsp_i  packed AXI; only AR and R are used, b_ready tied high
// Build option: define AXI_PACK_READER_SIGN_EXT_EN to honour desc_signed_i (sign extension).

package axi_pack_pkg;
  localparam int unsigned AddrW = 48;
  localparam int unsigned DataW = 64;
  localparam int unsigned IdW   = 4;

  typedef logic [31:0] stride_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    stride_t          user;
  } ax_t;

  typedef struct packed {
    logic [DataW-1:0]   data;
    logic [DataW/8-1:0] strb;
    logic               last;
  } w_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } r_t;

  typedef struct packed {
    ax_t  aw;
    logic aw_valid;
    w_t   w;
    logic w_valid;
    logic b_ready;
    ax_t  ar;
    logic ar_valid;
    logic r_ready;
  } axi_ssr_req_t;

  typedef struct packed {
    logic aw_ready;
    logic w_ready;
    b_t   b;
    logic b_valid;
    logic ar_ready;
    r_t   r;
    logic r_valid;
  } axi_ssr_rsp_t;
endpackage

module axi_pack_strided_reader #(
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned MaxBurstBeats  = 16,
  parameter int unsigned NumOutstanding = 4,
  parameter type axi_ssr_req_t = axi_pack_pkg::axi_ssr_req_t,
  parameter type axi_ssr_rsp_t = axi_pack_pkg::axi_ssr_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   desc_valid_i,
  output logic                   desc_ready_o,
  input  logic [AddrWidth-1:0]   desc_addr_i,
  input  axi_pack_pkg::stride_t  desc_stride_i,
  input  logic [2:0]             desc_size_i,
  input  logic [15:0]            desc_num_i,
  input  logic                   desc_signed_i,
  output logic [63:0]            elem_o,
  output logic                   elem_last_o,
  output logic                   elem_valid_o,
  input  logic                   elem_ready_i,
  output logic                   err_o,
  output logic                   busy_o,
  output axi_ssr_req_t           axi_ssr_req_o,
  input  axi_ssr_rsp_t           axi_ssr_rsp_i
);
  localparam int unsigned Bpb = DataWidth / 8;
  localparam int unsigned LW  = $clog2(Bpb);
  localparam int unsigned PW  = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam int unsigned CW  = $clog2(NumOutstanding + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   cur_addr_q, cur_addr_d;
  logic [15:0]            remaining_q, remaining_d;
  logic [15:0]            num_q, ecnt_q, ecnt_d, bcnt_q, bcnt_d;
  logic [LW-1:0]          lane_q, lane_d;
  logic [1:0]             size_q;
  axi_pack_pkg::stride_t  stride_q;
  logic                   err_q, err_d;
`ifdef AXI_PACK_READER_SIGN_EXT_EN
  logic                   signed_q;
`endif

  // Burst-info FIFO: element count of each issued, not yet fully returned burst.
  logic [15:0]   fifo_q [NumOutstanding];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          fifo_full, fifo_empty, push, pop;
  logic [15:0]   head;

  logic [31:0]          epb, max_burst, beats, log2_epb;
  logic [15:0]          burst_elems;
  logic [LW-1:0]        epb_m1, byte_off;
  logic [LW+2:0]        bit_off;
  logic [DataWidth-1:0] shifted;
  logic [63:0]          raw, ext;
  logic [AddrWidth-1:0] step;
  logic                 accept, ar_vld, ar_hs, burst_end, beat_end, el_hs, r_rdy;
  logic                 unused_sig;

  assign accept     = desc_valid_i & desc_ready_o;
  assign fifo_full  = (cnt_q == CW'(NumOutstanding));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // Burst sizing: at most MaxBurstBeats beats of EPB elements each.
  always_comb begin
    epb         = 32'(Bpb) >> size_q;
    log2_epb    = 32'(LW) - {30'd0, size_q};
    max_burst   = 32'(MaxBurstBeats) * epb;
    burst_elems = ({16'd0, remaining_q} < max_burst) ? remaining_q : max_burst[15:0];
    beats       = ({16'd0, burst_elems} + epb - 32'd1) >> log2_epb;
    epb_m1      = LW'(epb - 32'd1);
    step        = AddrWidth'(burst_elems) * AddrWidth'(stride_q);
  end

  // AR is only raised with FIFO room; once up, nothing but its own handshake can fill the FIFO, so it stays stable.
  assign ar_vld = (state_q == ISSUE) & ~fifo_full;
  assign ar_hs  = ar_vld & axi_ssr_rsp_i.ar_ready;

  // Unpack: the head burst's element counter decides where the beat (and burst) really ends.
  assign elem_valid_o = axi_ssr_rsp_i.r_valid & ~fifo_empty;
  assign burst_end    = ((bcnt_q + 16'd1) == head);
  assign beat_end     = (lane_q == epb_m1) | burst_end;
  assign el_hs        = elem_valid_o & elem_ready_i;
  assign r_rdy        = el_hs & beat_end;
  assign push         = ar_hs;
  assign pop          = el_hs & burst_end;

  always_comb begin
    byte_off = lane_q << size_q;
    bit_off  = {byte_off, 3'b000};
    shifted  = axi_ssr_rsp_i.r.data >> bit_off;
    raw      = shifted[63:0];
    case (size_q)
      2'd0:    ext = {56'd0, raw[7:0]};
      2'd1:    ext = {48'd0, raw[15:0]};
      2'd2:    ext = {32'd0, raw[31:0]};
      default: ext = raw;
    endcase
`ifdef AXI_PACK_READER_SIGN_EXT_EN
    if (signed_q) begin
      case (size_q)
        2'd0:    ext = {{56{raw[7]}}, raw[7:0]};
        2'd1:    ext = {{48{raw[15]}}, raw[15:0]};
        2'd2:    ext = {{32{raw[31]}}, raw[31:0]};
        default: ext = raw;
      endcase
    end
`endif
  end

  assign elem_o       = elem_valid_o ? ext : 64'd0;
  assign elem_last_o  = elem_valid_o & (ecnt_q == (num_q - 16'd1));
  assign desc_ready_o = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign err_o        = err_q;

  always_comb begin
    axi_ssr_req_o          = '0;
    axi_ssr_req_o.b_ready  = 1'b1;
    axi_ssr_req_o.ar.id    = '0;
    axi_ssr_req_o.ar.addr  = cur_addr_q;
    axi_ssr_req_o.ar.len   = 8'(beats - 32'd1);
    axi_ssr_req_o.ar.size  = {1'b0, size_q};
    axi_ssr_req_o.ar.burst = 2'b01;
    axi_ssr_req_o.ar.user  = stride_q;
    axi_ssr_req_o.ar_valid = ar_vld;
    axi_ssr_req_o.r_ready  = r_rdy;
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    lane_d      = lane_q;
    bcnt_d      = bcnt_q;
    ecnt_d      = ecnt_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (desc_valid_i) begin
          state_d     = ISSUE;
          cur_addr_d  = desc_addr_i;
          remaining_d = desc_num_i;
        end
      end
      ISSUE: begin
        if (ar_hs) begin
          cur_addr_d  = cur_addr_q + step;
          remaining_d = remaining_q - burst_elems;
          if (remaining_q == burst_elems) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (el_hs && elem_last_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (el_hs) begin
      ecnt_d = ecnt_q + 16'd1;
      lane_d = beat_end ? '0 : lane_q + 1'b1;
      bcnt_d = burst_end ? 16'd0 : bcnt_q + 16'd1;
    end
    // A beat must carry r.last exactly when it closes its burst.
    if (accept) begin
      ecnt_d = 16'd0;
      err_d  = 1'b0;
    end else if (r_rdy && ((axi_ssr_rsp_i.r.resp != 2'b00) || (axi_ssr_rsp_i.r.last != burst_end))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      num_q       <= '0;
      ecnt_q      <= '0;
      bcnt_q      <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      stride_q    <= '0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
`ifdef AXI_PACK_READER_SIGN_EXT_EN
      signed_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      ecnt_q      <= ecnt_d;
      bcnt_q      <= bcnt_d;
      lane_q      <= lane_d;
      err_q       <= err_d;
      if (accept) begin
        num_q    <= desc_num_i;
        size_q   <= desc_size_i[1:0];
        stride_q <= desc_stride_i;
`ifdef AXI_PACK_READER_SIGN_EXT_EN
        signed_q <= desc_signed_i;
`endif
      end
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(NumOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(NumOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= burst_elems;
  end

  assign unused_sig = ^{desc_signed_i, desc_size_i[2], axi_ssr_rsp_i, shifted};

endmodule

// File: tb/tb_axi_pack_strided_reader.sv
module tb_axi_pack_strided_reader;
  import axi_pack_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         desc_valid, desc_ready, desc_signed;
  logic [47:0]  desc_addr;
  stride_t      desc_stride;
  logic [2:0]   desc_size;
  logic [15:0]  desc_num;
  logic [63:0]  elem;
  logic         elem_last, elem_valid, elem_ready, err, busy;
  axi_ssr_req_t req;
  axi_ssr_rsp_t rsp;

  logic         tb_ar_ready, tb_r_valid, tb_r_last;
  logic [63:0]  tb_r_data;
  logic [1:0]   tb_r_resp;

  always_comb begin
    rsp          = '0;
    rsp.ar_ready = tb_ar_ready;
    rsp.r_valid  = tb_r_valid;
    rsp.r.data   = tb_r_data;
    rsp.r.last   = tb_r_last;
    rsp.r.resp   = tb_r_resp;
  end

  axi_pack_strided_reader #(
    .AddrWidth(48), .DataWidth(64), .AxiIdWidth(4), .MaxBurstBeats(4), .NumOutstanding(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .desc_valid_i(desc_valid), .desc_ready_o(desc_ready), .desc_addr_i(desc_addr),
    .desc_stride_i(desc_stride), .desc_size_i(desc_size), .desc_num_i(desc_num),
    .desc_signed_i(desc_signed),
    .elem_o(elem), .elem_last_o(elem_last), .elem_valid_o(elem_valid), .elem_ready_i(elem_ready),
    .err_o(err), .busy_o(busy),
    .axi_ssr_req_o(req), .axi_ssr_rsp_i(rsp)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory image: byte value as a function of its address.
  function automatic logic [7:0] byte_at(input logic [47:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return lo * 8'd7 + a[15:8];
  endfunction

  function automatic logic [63:0] elem_val(input logic [47:0] base, input stride_t st,
                                           input logic [1:0] sz, input int idx);
    logic [63:0] v;
    logic [47:0] ea;
    v  = '0;
    ea = base + 48'(idx) * 48'(st);
    for (int b = 0; b < (1 << sz); b++) v[8*b +: 8] = byte_at(ea + 48'(b));
    return v;
  endfunction

  function automatic logic [63:0] beat_data(input ax_t ax, input int beat);
    logic [63:0] d;
    int sz, lane, bb, e;
    d  = '0;
    sz = int'(ax.size[1:0]);
    for (int b = 0; b < 8; b++) begin
      lane = b >> sz;
      bb   = b & ((1 << sz) - 1);
      e    = beat * (8 >> sz) + lane;
      d[8*b +: 8] = byte_at(ax.addr + 48'(e) * 48'(ax.user) + 48'(bb));
    end
    return d;
  endfunction

  ax_t         ar_log[$];
  ax_t         ar_pend[$];
  logic [63:0] exp_q[$];
  int          rbeats = 0, rrdy_cnt = 0, err_beat = -1;
  bit          r_stall = 1'b0, rand_ready = 1'b0;
  int          rx_cnt = 0, job_num = 1, first_cyc = -1, last_cyc = 0, cyc = 0;
  logic [63:0] last_elem = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AR slave: always ready, logs every accepted request.
  initial begin
    tb_ar_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (req.ar_valid && tb_ar_ready) begin
        ar_log.push_back(req.ar);
        ar_pend.push_back(req.ar);
      end
    end
  end

  // R slave: serves bursts in order, beat data taken from the memory image.
  initial begin : r_slave
    ax_t cur;
    int  beat;
    bit  active, hs;
    cur = '0; beat = 0; active = 1'b0;
    tb_r_valid = 1'b0; tb_r_data = '0; tb_r_last = 1'b0; tb_r_resp = 2'b00;
    forever begin
      @(negedge clk);
      hs = tb_r_valid && req.r_ready;
      if (req.r_ready) rrdy_cnt++;
      if (hs) rbeats++;
      @(posedge clk);
      #1;
      if (hs) begin
        beat++;
        if (beat > int'(cur.len)) active = 1'b0;
      end
      if (!active && ar_pend.size() > 0) begin
        cur = ar_pend.pop_front();
        beat = 0;
        active = 1'b1;
      end
      tb_r_valid = active && !r_stall;
      tb_r_data  = active ? beat_data(cur, beat) : 64'd0;
      tb_r_last  = active && (beat == int'(cur.len));
      tb_r_resp  = (active && rbeats == err_beat) ? 2'b10 : 2'b00;
    end
  end

  // Element consumer and scoreboard; also checks hold stability while stalled.
  initial begin : consumer
    bit          hold;
    logic [63:0] hd, e;
    logic        hl;
    hold = 1'b0; hd = '0; hl = 1'b0;
    elem_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (hold) begin
        check("hold_valid", elem_valid, 1);
        check("hold_elem", elem, hd);
        check("hold_last", elem_last, hl);
      end
      if (elem_valid && elem_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        check($sformatf("elem%0d", rx_cnt), elem, e);
        check($sformatf("elem_last%0d", rx_cnt), elem_last, (rx_cnt == job_num - 1));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc  = cyc;
        last_elem = elem;
        rx_cnt++;
      end
      hold = elem_valid && !elem_ready;
      hd   = elem;
      hl   = elem_last;
      @(posedge clk);
      #1;
      elem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_job(input logic [47:0] a, input stride_t st, input logic [1:0] sz,
                           input int n, input bit sgn, input bit model);
    if (model) for (int i = 0; i < n; i++) exp_q.push_back(elem_val(a, st, sz, i));
    job_num = n; rx_cnt = 0; first_cyc = -1;
    @(posedge clk);
    #1;
    desc_valid = 1'b1; desc_addr = a; desc_stride = st; desc_size = {1'b0, sz};
    desc_num = 16'(n); desc_signed = sgn;
    @(negedge clk);
    check("desc_ready_idle", desc_ready, 1);
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    check("desc_ready_busy", desc_ready, 0);
    check("err_clear_on_accept", err, 0);
  endtask

  task automatic wait_job(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, busy, 0);
    check({tag, "_count"}, 64'(rx_cnt), 64'(job_num));
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    int a0, rb0, rr0, n;
    ax_t ax;
    desc_valid = 1'b0; desc_addr = '0; desc_stride = '0; desc_size = '0;
    desc_num = 16'd1; desc_signed = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_desc_ready", desc_ready, 1);
    check("rst_elem_valid", elem_valid, 0);
    check("rst_elem", elem, 0);
    check("rst_elem_last", elem_last, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_ar_valid", req.ar_valid, 0);
    check("rst_r_ready", req.r_ready, 0);
    check("rst_b_ready", req.b_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: one AR, partial last beat.
    a0 = ar_log.size(); rr0 = rrdy_cnt;
    start_job(48'h1000, 16, 2'd2, 5, 1'b0, 1'b1);
    wait_job("t1");
    check("t1_ar_count", 64'(ar_log.size() - a0), 1);
    ax = ar_log[a0];
    check("t1_ar_addr", ax.addr, 48'h1000);
    check("t1_ar_len", ax.len, 2);
    check("t1_ar_size", ax.size, 2);
    check("t1_ar_user", ax.user, 16);
    check("t1_ar_burst", ax.burst, 1);
    check("t1_ar_id", ax.id, 0);
    check("t1_r_ready_pulses", 64'(rrdy_cnt - rr0), 3);

    // 2: burst split plus one element per cycle.
    a0 = ar_log.size();
    start_job(48'h200, 3, 2'd0, 40, 1'b0, 1'b1);
    wait_job("t2");
    check("t2_ar_count", 64'(ar_log.size() - a0), 2);
    ax = ar_log[a0];
    check("t2_ar0_addr", ax.addr, 48'h200);
    check("t2_ar0_len", ax.len, 3);
    ax = ar_log[a0 + 1];
    check("t2_ar1_addr", ax.addr, 48'h260);
    check("t2_ar1_len", ax.len, 0);
    check("t2_zero_bubble", 64'(last_cyc - first_cyc), 39);

    // 3: outstanding limit with R stalled.
    a0 = ar_log.size(); rb0 = rbeats;
    r_stall = 1'b1;
    start_job(48'h5000, 8, 2'd3, 12, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("t3_ar_stalled_count", 64'(ar_log.size() - a0), 2);
    check("t3_ar_valid_low", req.ar_valid, 0);
    check("t3_no_beats", 64'(rbeats - rb0), 0);
    r_stall = 1'b0;
    n = 0;
    while (ar_log.size() < a0 + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t3_third_ar", 64'(ar_log.size() - a0), 3);
    check("t3_third_after_burst", 64'(rbeats - rb0 >= 4), 1);
    if (ar_log.size() >= a0 + 3) begin
      ax = ar_log[a0 + 2];
      check("t3_ar2_addr", ax.addr, 48'h5040);
    end
    wait_job("t3");

    // 4: random output throttling.
    a0 = ar_log.size();
    rand_ready = 1'b1;
    start_job(48'h3000, 6, 2'd1, 100, 1'b0, 1'b1);
    wait_job("t4");
    rand_ready = 1'b0;
    check("t4_ar_count", 64'(ar_log.size() - a0), 7);

    // 5: SLVERR on the second beat, sticky until next accept.
    check("t5_err_before", err, 0);
    err_beat = rbeats + 1;
    start_job(48'h4000, 8, 2'd3, 3, 1'b0, 1'b1);
    wait_job("t5");
    check("t5_err_set", err, 1);
    repeat (5) @(negedge clk);
    check("t5_err_held", err, 1);
    err_beat = -1;

    // Zero stride: every element is the same word (accept also clears err).
    start_job(48'h2002, 0, 2'd1, 6, 1'b0, 1'b1);
    wait_job("t6");
    check("t6_err_after", err, 0);

    // Sign extension of byte 0x80 at address 0x80.
`ifdef AXI_PACK_READER_SIGN_EXT_EN
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FF80);
`else
    exp_q.push_back(64'h0000_0000_0000_0080);
`endif
    start_job(48'h80, 5, 2'd0, 1, 1'b1, 1'b0);
    wait_job("t7");
`ifdef AXI_PACK_READER_SIGN_EXT_EN
    check("t7_sign_ext", last_elem, 64'hFFFF_FFFF_FFFF_FF80);
`else
    check("t7_zero_ext", last_elem, 64'h0000_0000_0000_0080);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
